// File: rtl/score_keeper_if.sv
// score_keeper_if: event inputs from the game stage and the credit/status
// outputs that go to the display and the top-level state machine.
// Optional macro SCORE_KEEPER_JACKPOT7_EN adds the jackpot_p status line.
interface score_keeper_if;
    logic [3:0] cur_state;
    logic       coin_p;
    logic       score_reset;
    logic       turn_p;
    logic [3:0] number1;
    logic [3:0] number2;
    logic [3:0] number3;
    logic [3:0] credit_tens;
    logic [3:0] credit_ones;
    logic [6:0] last_win;
    logic       win_p;
    logic       err_p;
    logic       no_credit;
    logic       busy;
`ifdef SCORE_KEEPER_JACKPOT7_EN
    logic       jackpot_p;
`endif

    // Driver side: game stage / top level
    modport master (
        output cur_state, coin_p, score_reset, turn_p, number1, number2, number3,
        input  credit_tens, credit_ones, last_win, win_p, err_p, no_credit, busy
`ifdef SCORE_KEEPER_JACKPOT7_EN
        , input jackpot_p
`endif
    );

    // Score keeper side
    modport slave (
        input  cur_state, coin_p, score_reset, turn_p, number1, number2, number3,
        output credit_tens, credit_ones, last_win, win_p, err_p, no_credit, busy
`ifdef SCORE_KEEPER_JACKPOT7_EN
        , output jackpot_p
`endif
    );
endinterface

// File: rtl/score_keeper.sv
// score_keeper: two-digit BCD credit balance. Charges a bet on each turn
// start, evaluates the latched reels at turn end and pays winnings (or coin
// credit) one unit per clock, saturating at MAX_CREDIT.
// Optional macro SCORE_KEEPER_JACKPOT7_EN: triple 7 pays JACKPOT_PAY and
// pulses jackpot_p alongside win_p.
module score_keeper #(
    parameter int BET         = 1,
    parameter int PAY_PAIR    = 2,
    parameter int PAY_TRIPLE  = 10,
    parameter int COIN_VALUE  = 5,
    parameter int MAX_CREDIT  = 99,
    parameter int INIT_CREDIT = 10
`ifdef SCORE_KEEPER_JACKPOT7_EN
    , parameter int JACKPOT_PAY = 50
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    score_keeper_if.slave bus
);
    localparam logic [3:0] COIN_STATE = 4'b0100;
    localparam logic [3:0] BET_T  = 4'(BET / 10);
    localparam logic [3:0] BET_O  = 4'(BET % 10);
    localparam logic [3:0] INIT_T = 4'(INIT_CREDIT / 10);
    localparam logic [3:0] INIT_O = 4'(INIT_CREDIT % 10);
    localparam logic [3:0] MAX_T  = 4'(MAX_CREDIT / 10);
    localparam logic [3:0] MAX_O  = 4'(MAX_CREDIT % 10);

    typedef enum logic [1:0] {IDLE, CHARGE, EVAL, PAY} state_t;
    state_t state, next_state;

    logic [3:0] tens, ones;
    logic [3:0] reel1, reel2, reel3;
    logic [6:0] units, last_win, payout, credit_bin;
    logic       sr_q, pend_charge, pend_turn, pend_coin;
    logic       svc_charge, svc_turn, svc_coin;
    logic       win_p, err_p, can_pay, at_max;
`ifdef SCORE_KEEPER_JACKPOT7_EN
    logic       jackpot, jackpot_p;
`endif

    // Digits are always 0..9, so the binary value fits in 7 bits
    assign credit_bin = 7'(tens) * 7'd10 + 7'(ones);
    assign can_pay    = credit_bin >= 7'(BET);
    assign at_max     = (tens == MAX_T) && (ones == MAX_O);

    // Payout for the latched reels; all comparisons are on the full nibble
    always_comb begin
        payout = '0;
`ifdef SCORE_KEEPER_JACKPOT7_EN
        jackpot = 1'b0;
`endif
        if (reel1 == reel2 && reel2 == reel3) begin
            payout = 7'(PAY_TRIPLE);
`ifdef SCORE_KEEPER_JACKPOT7_EN
            if (reel1 == 4'h7) begin
                payout  = 7'(JACKPOT_PAY);
                jackpot = 1'b1;
            end
`endif
        end else if (reel1 == reel2 || reel2 == reel3 || reel1 == reel3) begin
            payout = 7'(PAY_PAIR);
        end
    end

    // Next state; IDLE services pending work as charge > turn > coin
    always_comb begin
        next_state = state;
        svc_charge = 1'b0;
        svc_turn   = 1'b0;
        svc_coin   = 1'b0;
        case (state)
            IDLE: begin
                if (pend_charge) begin
                    svc_charge = 1'b1;
                    next_state = CHARGE;
                end else if (pend_turn) begin
                    svc_turn   = 1'b1;
                    next_state = EVAL;
                end else if (pend_coin) begin
                    svc_coin   = 1'b1;
                    next_state = PAY;
                end
            end
            CHARGE:  next_state = IDLE;
            EVAL:    next_state = (payout != '0) ? PAY : IDLE;
            PAY:     if (at_max || units <= 7'd1) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Event capture: hold each event until IDLE services it; a repeat while
    // still pending is absorbed. A new event wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q        <= 1'b0;
            pend_charge <= 1'b0;
            pend_turn   <= 1'b0;
            pend_coin   <= 1'b0;
            reel1       <= '0;
            reel2       <= '0;
            reel3       <= '0;
        end else begin
            sr_q        <= bus.score_reset;
            pend_charge <= (pend_charge & ~svc_charge) | (bus.score_reset & ~sr_q);
            pend_turn   <= (pend_turn & ~svc_turn) | bus.turn_p;
            pend_coin   <= (pend_coin & ~svc_coin) |
                           (bus.coin_p && bus.cur_state == COIN_STATE);
            if (bus.turn_p) begin
                reel1 <= bus.number1;
                reel2 <= bus.number2;
                reel3 <= bus.number3;
            end
        end
    end

    // Credit arithmetic, payout countdown and one-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens     <= INIT_T;
            ones     <= INIT_O;
            units    <= '0;
            last_win <= '0;
            win_p    <= 1'b0;
            err_p    <= 1'b0;
`ifdef SCORE_KEEPER_JACKPOT7_EN
            jackpot_p <= 1'b0;
`endif
        end else begin
            win_p <= 1'b0;
            err_p <= 1'b0;
`ifdef SCORE_KEEPER_JACKPOT7_EN
            jackpot_p <= 1'b0;
`endif
            if (svc_coin) units <= 7'(COIN_VALUE);
            case (state)
                CHARGE: begin
                    if (!can_pay) begin
                        err_p <= 1'b1;
                    end else if (ones < BET_O) begin
                        // Borrow from tens; result is back in 0..9 mod 16
                        ones <= ones + 4'd10 - BET_O;
                        tens <= tens - BET_T - 4'd1;
                    end else begin
                        ones <= ones - BET_O;
                        tens <= tens - BET_T;
                    end
                end
                EVAL: begin
                    last_win <= payout;
                    units    <= payout;
                    win_p    <= (payout != '0);
`ifdef SCORE_KEEPER_JACKPOT7_EN
                    jackpot_p <= jackpot;
`endif
                end
                PAY: begin
                    if (at_max || units == '0) begin
                        units <= '0;  // ceiling reached: drop the remainder
                    end else begin
                        units <= units - 7'd1;
                        if (ones == 4'd9) begin
                            ones <= 4'd0;
                            tens <= tens + 4'd1;
                        end else begin
                            ones <= ones + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.credit_tens = tens;
    assign bus.credit_ones = ones;
    assign bus.last_win    = last_win;
    assign bus.win_p       = win_p;
    assign bus.err_p       = err_p;
    assign bus.no_credit   = ~can_pay;
    assign bus.busy        = (state != IDLE);
`ifdef SCORE_KEEPER_JACKPOT7_EN
    assign bus.jackpot_p   = jackpot_p;
`endif
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed vectors for score_keeper plus hand-timed
// sequences for latency, saturation, same-cycle events and async reset.
// Honours SCORE_KEEPER_JACKPOT7_EN for the triple-7 check.
module tb_score_keeper;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    score_keeper_if bus();
    score_keeper dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       chg;      // charge a bet before the turn
        logic [3:0] n1, n2, n3;
        int         lw;       // expected last_win
        int         wins;     // expected win_p pulses
        int         bcyc;     // expected busy cycles after turn_p
        int         credit;   // expected credit when idle again
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_credit(input string name, input int exp);
        chk({name, " tens"}, int'(bus.credit_tens), exp / 10);
        chk({name, " ones"}, int'(bus.credit_ones), exp % 10);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_turn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        bus.number1 = a;
        bus.number2 = b;
        bus.number3 = c;
        bus.turn_p  = 1'b1;
        tick();
        bus.turn_p  = 1'b0;
    endtask

    task automatic pulse_charge();
        bus.score_reset = 1'b1;
        tick();
        bus.score_reset = 1'b0;
    endtask

    task automatic pulse_coin();
        bus.coin_p = 1'b1;
        tick();
        bus.coin_p = 1'b0;
    endtask

    // Run until three consecutive idle samples, counting busy cycles and pulses
    task automatic run_idle(output int bcyc, output int wins, output int errs, output int jacks);
        int quiet = 0;
        int n = 0;
        bcyc = 0; wins = 0; errs = 0; jacks = 0;
        while (quiet < 3 && n < 300) begin
            tick();
            n++;
            if (bus.busy) begin bcyc++; quiet = 0; end
            else quiet++;
            if (bus.win_p) wins++;
            if (bus.err_p) errs++;
`ifdef SCORE_KEEPER_JACKPOT7_EN
            if (bus.jackpot_p) jacks++;
`endif
        end
        if (quiet < 3) begin
            n_vec++;
            n_bad++;
            $display("FAIL run_idle: still busy after %0d cycles, expected idle", n);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

    initial begin
        int b, w, e, j, guard;
        bus.cur_state   = 4'd0;
        bus.coin_p      = 1'b0;
        bus.score_reset = 1'b0;
        bus.turn_p      = 1'b0;
        bus.number1     = 4'd0;
        bus.number2     = 4'd0;
        bus.number3     = 4'd0;

        vecs[0] = '{1'b1, 4'h2, 4'h5, 4'h2, 2,  1, 3,  20};
        vecs[1] = '{1'b1, 4'h1, 4'h2, 4'h4, 0,  0, 1,  19};
        vecs[2] = '{1'b0, 4'h4, 4'h4, 4'h9, 2,  1, 3,  21};
        vecs[3] = '{1'b0, 4'h0, 4'h4, 4'h4, 2,  1, 3,  23};
        vecs[4] = '{1'b0, 4'h6, 4'h1, 4'h6, 2,  1, 3,  25};
        vecs[5] = '{1'b1, 4'hF, 4'hF, 4'hF, 10, 1, 11, 34};
        vecs[6] = '{1'b1, 4'h8, 4'h9, 4'hA, 0,  0, 1,  33};
        vecs[7] = '{1'b0, 4'h5, 4'h5, 4'h5, 10, 1, 11, 43};

        // Reset state
        repeat (3) tick();
        chk_credit("reset credit", 10);
        chk("reset last_win", int'(bus.last_win), 0);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset win_p", int'(bus.win_p), 0);
        chk("reset err_p", int'(bus.err_p), 0);
        chk("reset no_credit", int'(bus.no_credit), 0);
        rst_n = 1'b1;
        tick();

        // First bet: 10 -> 09 with BCD borrow
        pulse_charge();
        run_idle(b, w, e, j);
        chk_credit("bet 10", 9);
        chk("bet 10 err_p", e, 0);
        chk("bet 10 no_credit", int'(bus.no_credit), 0);

        // Triple 3: exact latency and one unit per clock
        pulse_turn(4'h3, 4'h3, 4'h3);          // edge t
        tick();                                 // t+1: EVAL
        chk("t333 busy eval", int'(bus.busy), 1);
        tick();                                 // t+2: decided
        chk("t333 win_p", int'(bus.win_p), 1);
        chk("t333 last_win", int'(bus.last_win), 10);
        chk_credit("t333 pre-pay", 9);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk_credit($sformatf("t333 pay%0d", k), 9 + k);
            chk($sformatf("t333 busy%0d", k), int'(bus.busy), (k < 10) ? 1 : 0);
            if (k == 1) chk("t333 win_p width", int'(bus.win_p), 0);
        end
        tick();

        // Table of turns
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].chg) begin
                pulse_charge();
                run_idle(b, w, e, j);
            end
            pulse_turn(vecs[i].n1, vecs[i].n2, vecs[i].n3);
            run_idle(b, w, e, j);
            chk($sformatf("vec%0d last_win", i), int'(bus.last_win), vecs[i].lw);
            chk($sformatf("vec%0d win_p", i), w, vecs[i].wins);
            chk($sformatf("vec%0d busy", i), b, vecs[i].bcyc);
            chk_credit($sformatf("vec%0d credit", i), vecs[i].credit);
        end

        // Drain to zero, then a charge with no credit
        guard = 0;
        while ((bus.credit_tens != 4'd0 || bus.credit_ones != 4'd0) && guard < 100) begin
            pulse_charge();
            run_idle(b, w, e, j);
            guard++;
        end
        chk_credit("drained", 0);
        chk("drained no_credit", int'(bus.no_credit), 1);
        pulse_charge();
        run_idle(b, w, e, j);
        chk("empty err_p", e, 1);
        chk_credit("empty credit", 0);

        // Coin outside COIN state is ignored; inside it adds COIN_VALUE
        bus.cur_state = 4'b0011;
        pulse_coin();
        run_idle(b, w, e, j);
        chk_credit("coin ignored", 0);
        chk("coin ignored busy", b, 0);
        bus.cur_state = 4'b0100;
        pulse_coin();
        run_idle(b, w, e, j);
        chk_credit("coin", 5);
        chk("coin busy", b, 5);
        chk("coin win_p", w, 0);
        chk("coin last_win", int'(bus.last_win), 10);
        chk("coin no_credit", int'(bus.no_credit), 0);

        // Climb to 95, then a triple saturates at 99
        for (int i = 0; i < 18; i++) begin
            pulse_coin();
            run_idle(b, w, e, j);
        end
        bus.cur_state = 4'd0;
        chk_credit("coins 95", 95);
        pulse_turn(4'h3, 4'h3, 4'h3);
        run_idle(b, w, e, j);
        chk_credit("saturate", 99);
        chk("saturate busy", b, 6);
        chk("saturate last_win", int'(bus.last_win), 10);

        // turn_p and score_reset edge together: charge first, then EVAL
        bus.number1 = 4'h1;
        bus.number2 = 4'h1;
        bus.number3 = 4'h2;
        bus.turn_p = 1'b1;
        bus.score_reset = 1'b1;
        tick();                                 // t
        bus.turn_p = 1'b0;
        bus.score_reset = 1'b0;
        tick();                                 // t+1: CHARGE
        chk("both charge busy", int'(bus.busy), 1);
        chk_credit("both pre-charge", 99);
        tick();                                 // t+2: back to IDLE
        chk_credit("both charged", 98);
        chk("both idle gap", int'(bus.busy), 0);
        tick();                                 // t+3: EVAL
        chk("both eval busy", int'(bus.busy), 1);
        tick();                                 // t+4
        chk("both win_p", int'(bus.win_p), 1);
        chk("both last_win", int'(bus.last_win), 2);
        run_idle(b, w, e, j);
        chk_credit("both final", 99);

        // Asynchronous reset in the middle of PAY
        pulse_charge();
        run_idle(b, w, e, j);
        rst_n = 1'b0;
        #1;
        chk_credit("async rst", 10);
        tick();
        rst_n = 1'b1;
        pulse_charge();
        run_idle(b, w, e, j);
        pulse_turn(4'h8, 4'h8, 4'h8);
        repeat (5) tick();                      // t+5: third unit paid
        chk_credit("mid-pay", 12);
        chk("mid-pay busy", int'(bus.busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_credit("rst mid-pay", 10);
        chk("rst mid-pay busy", int'(bus.busy), 0);
        chk("rst mid-pay last_win", int'(bus.last_win), 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk_credit("after rst", 10);
        chk("after rst busy", int'(bus.busy), 0);

        // Triple 7
        pulse_charge();
        run_idle(b, w, e, j);
        pulse_turn(4'h7, 4'h7, 4'h7);
        run_idle(b, w, e, j);
        chk("t777 win_p", w, 1);
`ifdef SCORE_KEEPER_JACKPOT7_EN
        chk("t777 last_win", int'(bus.last_win), 50);
        chk("t777 jackpot_p", j, 1);
        chk_credit("t777 credit", 59);
`else
        chk("t777 last_win", int'(bus.last_win), 10);
        chk_credit("t777 credit", 19);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Downstream of the reel/game stage: consumes number1..3, score_reset and turn_p.
- Keeps the player's credit balance as two BCD digits (0..99).
- On each turn start, charges a bet; on turn_p, evaluates the three reels and pays out winnings one unit per clock.
- Drives the score display digits and the status flags used by the top-level state machine (WELCOME/GAME/SCORE/ERROR/COIN).

Parameters:
- BET, 1, credits charged per turn
- PAY_PAIR, 2, payout when exactly two reels match
- PAY_TRIPLE, 10, payout when all three reels match
- COIN_VALUE, 5, credits added per accepted coin
- MAX_CREDIT, 99, saturation ceiling (binary value, must be ≤99)
- INIT_CREDIT, 10, credit after reset

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cur_state  in  4  top-level state; COIN = 4'b0100
- coin_p  in  1  one-cycle coin-insert pulse; honoured only while cur_state==COIN
- score_reset  in  1  level from game stage, high while a new turn starts; rising edge = charge bet
- turn_p  in  1  one-cycle end-of-turn pulse
- number1, number2, number3  in  4 each  final reel values
- credit_tens, credit_ones  out  4 each  BCD credit
- last_win  out  7  payout of most recent evaluated turn
- win_p  out  1  one-cycle pulse when a nonzero payout is decided
- err_p  out  1  one-cycle pulse when a charge occurs with credit < BET
- no_credit  out  1  level, credit < BET
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n low): credit = INIT_CREDIT (tens=1, ones=0 at defaults); last_win=0; win_p=err_p=0; busy=0; all pending flags clear; state IDLE.
- Event capture, every cycle, any state:
  - Rising edge of score_reset (registered previous value, reset 0) sets pend_charge.
  - turn_p sets pend_turn and latches number1..3 into reel regs.
  - coin_p with cur_state==COIN sets pend_coin.
  - An event arriving while its flag is already set is lost (flag stays 1).
- FSM states IDLE, CHARGE, EVAL, PAY.
- IDLE services pending flags in fixed priority charge > turn > coin; clears the serviced flag on the transition edge.
  - pend_charge → CHARGE.
  - pend_turn → EVAL.
  - pend_coin → PAY with units=COIN_VALUE; no win_p, last_win unchanged.
- CHARGE, one cycle:
  - If credit ≥ BET: credit -= BET (BCD borrow).
  - Else: credit unchanged and err_p pulses.
  - → IDLE.
- EVAL, one cycle, on latched reels:
  - All equal → PAY_TRIPLE.
  - Any two equal → PAY_PAIR.
  - Else 0.
  - Comparisons on full 4 bits.
  - last_win ← payout. win_p pulses if payout > 0.
  - payout > 0 → PAY with units=payout; else → IDLE.
- PAY: each cycle, credit += 1 (BCD: ones 9→0 carries into tens) and units -= 1.
  - Exit to IDLE when units reaches 0.
  - If credit == MAX_CREDIT: units cleared, → IDLE; remainder is discarded.
- Latency (turn_p at edge t, FSM idle, no charge pending): EVAL at t+2, first credit increment visible after edge t+3, final after edge t+2+payout.
- no_credit is combinational from the credit registers.
- busy = (state != IDLE).
- BCD digits are never outside 0..9; credit never exceeds MAX_CREDIT or goes below 0.

Optional Feature:
- Macro: SCORE_KEEPER_JACKPOT7_EN.
- When defined: triple 4'h7 pays parameter JACKPOT_PAY (default 50) instead of PAY_TRIPLE, and output jackpot_p pulses together with win_p.
- When undefined: no JACKPOT_PAY parameter, no jackpot_p port; triple 7 pays PAY_TRIPLE.

Test Plan:
- Reset, then score_reset rising → credit 10→09; no_credit=0; err_p silent.
- Reels 3,3,3 then turn_p → last_win=10, win_p one cycle, credit 09→19, incremented over 10 consecutive cycles; busy high throughout PAY.
- Reels 2,5,2 → payout 2; reels 1,2,4 → payout 0, no win_p, FSM back to IDLE after EVAL.
- Credit 00 plus score_reset edge → err_p pulse, credit stays 00, no_credit=1. Then cur_state=COIN with coin_p → credit 05.
- Credit 95 and triple win → credit saturates at 99, remaining units dropped, FSM returns to IDLE.
- turn_p and score_reset edge in the same cycle → charge serviced first, then EVAL. rst_n low mid-PAY → credit=10 immediately, state IDLE. With SCORE_KEEPER_JACKPOT7_EN defined, 7,7,7 → last_win=50, jackpot_p pulses.
